// File: rtl/conv_backward_input.sv
// conv_backward_input
//   Sequential backward-data pass of a stride-1, "same"-padded convolution.
//   For every input-gradient element (ci,i,j) it walks all (co,m,n) taps
//   of the forward kernel, one tap per clock, accumulating
//   grad_out[co][i-m*D+P][j-n*D+P] * kernels[m][n][ci][co] in a wide
//   signed accumulator. It then writes (acc >>> FRAC), truncated to DATA_W,
//   into grad_in in a single WRITE cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears grad_in too)
//   start     begins a pass when sampled high in IDLE
//   grad_out  [OUT_DEPTH][IN_HEIGHT][IN_WIDTH] gradient w.r.t. conv output
//   kernels   [K][K][IN_DEPTH][OUT_DEPTH] forward weights
//   busy      high while accumulating / writing
//   done      one-cycle completion pulse
//   grad_in   [IN_DEPTH][IN_HEIGHT][IN_WIDTH] registered result
module conv_backward_input #(
    parameter int IN_DEPTH    = 3,
    parameter int IN_HEIGHT   = 4,
    parameter int IN_WIDTH    = 4,
    parameter int OUT_DEPTH   = 2,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_W      = 16,
    parameter int FRAC        = 4,
    parameter int DILATION    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] grad_out [OUT_DEPTH][IN_HEIGHT][IN_WIDTH],
    input  logic signed [DATA_W-1:0] kernels  [KERNEL_SIZE][KERNEL_SIZE][IN_DEPTH][OUT_DEPTH],
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] grad_in  [IN_DEPTH][IN_HEIGHT][IN_WIDTH]
);

    // Index widths; a single-entry dimension still gets a 1-bit counter.
    localparam int CW    = (IN_DEPTH    > 1) ? $clog2(IN_DEPTH)    : 1;
    localparam int HW    = (IN_HEIGHT   > 1) ? $clog2(IN_HEIGHT)   : 1;
    localparam int WW    = (IN_WIDTH    > 1) ? $clog2(IN_WIDTH)    : 1;
    localparam int OW    = (OUT_DEPTH   > 1) ? $clog2(OUT_DEPTH)   : 1;
    localparam int KW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int PAD   = (KERNEL_SIZE / 2) * DILATION;
    localparam int ACC_W = 2 * DATA_W + 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] ci;
    logic [HW-1:0] i;
    logic [WW-1:0] j;
    logic [OW-1:0] co;
    logic [KW-1:0] m, n;

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    tap;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   go_sel, k_sel, res;
    int                         row_i, col_i;
    logic                       tap_ok, last_tap, last_elem;

    // Tap address in grad_out. Computed as int so that negative and
    // past-the-edge positions are caught before they are used as indices.
    always_comb begin
        row_i     = int'(i) - int'(m) * DILATION + PAD;
        col_i     = int'(j) - int'(n) * DILATION + PAD;
        tap_ok    = (row_i >= 0) && (row_i < IN_HEIGHT) &&
                    (col_i >= 0) && (col_i < IN_WIDTH);
        go_sel    = grad_out[co][HW'(row_i)][WW'(col_i)];
        k_sel     = kernels[m][n][ci][co];
        prod      = go_sel * k_sel;
        tap       = tap_ok ? ACC_W'(prod) : '0;
        res       = DATA_W'(acc >>> FRAC);
        last_tap  = (n == KW'(KERNEL_SIZE - 1)) && (m == KW'(KERNEL_SIZE - 1)) &&
                    (co == OW'(OUT_DEPTH - 1));
        last_elem = (j == WW'(IN_WIDTH - 1)) && (i == HW'(IN_HEIGHT - 1)) &&
                    (ci == CW'(IN_DEPTH - 1));
    end

    assign busy = (state == S_ACCUM) || (state == S_WRITE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ci    <= '0;
            i     <= '0;
            j     <= '0;
            co    <= '0;
            m     <= '0;
            n     <= '0;
            acc   <= '0;
            for (int a = 0; a < IN_DEPTH; a++)
                for (int b = 0; b < IN_HEIGHT; b++)
                    for (int c = 0; c < IN_WIDTH; c++)
                        grad_in[a][b][c] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCUM;
                        ci    <= '0;
                        i     <= '0;
                        j     <= '0;
                        co    <= '0;
                        m     <= '0;
                        n     <= '0;
                        acc   <= '0;
                    end
                end
                S_ACCUM: begin
                    // Out-of-range taps still take their cycle (tap = 0) so
                    // the pass length is independent of the data position.
                    acc <= acc + tap;
                    if (n == KW'(KERNEL_SIZE - 1)) begin
                        n <= '0;
                        if (m == KW'(KERNEL_SIZE - 1)) begin
                            m <= '0;
                            if (co == OW'(OUT_DEPTH - 1)) co <= '0;
                            else                          co <= co + OW'(1);
                        end else begin
                            m <= m + KW'(1);
                        end
                    end else begin
                        n <= n + KW'(1);
                    end
                    if (last_tap) state <= S_WRITE;
                end
                S_WRITE: begin
                    grad_in[ci][i][j] <= res;
                    acc <= '0;
                    if (j == WW'(IN_WIDTH - 1)) begin
                        j <= '0;
                        if (i == HW'(IN_HEIGHT - 1)) begin
                            i <= '0;
                            if (ci == CW'(IN_DEPTH - 1)) ci <= '0;
                            else                         ci <= ci + CW'(1);
                        end else begin
                            i <= i + HW'(1);
                        end
                    end else begin
                        j <= j + WW'(1);
                    end
                    state <= last_elem ? S_DONE : S_ACCUM;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_backward_input.sv
module tb_conv_backward_input;

    localparam int ID = 3, H = 4, W = 4, OD = 2, K = 3, DW = 16, FR = 4;
    localparam int NBUSY = ID * H * W * (OD * K * K + 1);   // 912

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, start2 = 1'b0;
    logic busy, done, busy2, done2;
    logic signed [DW-1:0] go  [OD][H][W];
    logic signed [DW-1:0] kr  [K][K][ID][OD];
    logic signed [DW-1:0] gi  [ID][H][W];
    logic signed [DW-1:0] gi2 [ID][H][W];
    logic signed [DW-1:0] expv [ID][H][W];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_backward_input dut (
        .clk(clk), .rst(rst), .start(start), .grad_out(go), .kernels(kr),
        .busy(busy), .done(done), .grad_in(gi));

    conv_backward_input #(.DILATION(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .grad_out(go), .kernels(kr),
        .busy(busy2), .done(done2), .grad_in(gi2));

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Direct evaluation of the backward-data sum for dilation d.
    task automatic model(input int d);
        int p, r, c;
        longint s;
        p = (K / 2) * d;
        for (int ci = 0; ci < ID; ci++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    s = 0;
                    for (int co = 0; co < OD; co++)
                        for (int mm = 0; mm < K; mm++)
                            for (int nn = 0; nn < K; nn++) begin
                                r = y - mm * d + p;
                                c = x - nn * d + p;
                                if (r >= 0 && r < H && c >= 0 && c < W)
                                    s += longint'(go[co][r][c]) * longint'(kr[mm][nn][ci][co]);
                            end
                    expv[ci][y][x] = DW'(s >>> FR);
                end
    endtask

    function automatic longint gi_of(input int which, input int a, input int b, input int c);
        return (which == 1) ? longint'(gi[a][b][c]) : longint'(gi2[a][b][c]);
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 1) ? busy : busy2;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 1) ? done : done2;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 1) start = v; else start2 = v;
    endtask

    task automatic check_model(input int which, input int d, input string tag);
        model(d);
        for (int a = 0; a < ID; a++)
            for (int b = 0; b < H; b++)
                for (int c = 0; c < W; c++)
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, a, b, c),
                        gi_of(which, a, b, c), longint'(expv[a][b][c]));
    endtask

    task automatic check_zero(input int which, input string tag);
        for (int a = 0; a < ID; a++)
            for (int b = 0; b < H; b++)
                for (int c = 0; c < W; c++)
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, a, b, c), gi_of(which, a, b, c), 0);
    endtask

    // One pass; inputs change on negedge, outputs sampled on negedge.
    // start_at / rst_at are busy-cycle numbers (0 = never).
    task automatic run_pass(input int which, input int start_at, input int rst_at,
                            input bit start_in_done, input string tag);
        int  nb;
        bit  aborted;
        nb = 0;
        aborted = 0;
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        while (busy_of(which) && nb < 3000) begin
            nb++;
            set_start(which, (nb == start_at) ? 1'b1 : 1'b0);
            chk({tag, "_done_low_while_busy"}, done_of(which), 0);
            if (nb == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        set_start(which, 1'b0);
        if (aborted) begin
            chk({tag, "_busy_after_rst"}, busy_of(which), 0);
            chk({tag, "_done_after_rst"}, done_of(which), 0);
        end else begin
            chk({tag, "_busy_cycles"}, nb, NBUSY);
            chk({tag, "_done_pulse"}, done_of(which), 1);
            if (start_in_done) set_start(which, 1'b1);
            @(negedge clk);
            set_start(which, 1'b0);
            chk({tag, "_done_one_cycle"}, done_of(which), 0);
            chk({tag, "_idle_after_done"}, busy_of(which), 0);
        end
    endtask

    task automatic fill(input int gv, input int kv);
        for (int a = 0; a < OD; a++)
            for (int b = 0; b < H; b++)
                for (int c = 0; c < W; c++) go[a][b][c] = DW'(gv);
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                for (int c = 0; c < ID; c++)
                    for (int e = 0; e < OD; e++) kr[a][b][c][e] = DW'(kv);
    endtask

    task automatic fill_rand(input bit full);
        for (int a = 0; a < OD; a++)
            for (int b = 0; b < H; b++)
                for (int c = 0; c < W; c++)
                    go[a][b][c] = full ? DW'($urandom) : DW'(int'($urandom_range(0, 255)) - 128);
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                for (int c = 0; c < ID; c++)
                    for (int e = 0; e < OD; e++)
                        kr[a][b][c][e] = full ? DW'($urandom) : DW'(int'($urandom_range(0, 255)) - 128);
    endtask

    initial begin
        fill(0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_zero(1, "rst_gi");

        // All ones (1.0 in Q4): interior 18 taps, corner 8, edge 12.
        fill(16, 16);
        run_pass(1, 0, 0, 0, "ones");
        for (int c = 0; c < ID; c++) begin
            chk("ones_11", gi[c][1][1], 288);
            chk("ones_00", gi[c][0][0], 128);
            chk("ones_01", gi[c][0][1], 192);
        end
        check_model(1, 1, "ones");

        // Single tap: kernels[0][0] pairs grad_out[i+1][j+1] with grad_in[i][j].
        fill(0, 0);
        go[0][1][1] = 16'sd16;
        kr[0][0][0][0] = 16'sd32;
        run_pass(1, 0, 0, 0, "orient");
        chk("orient_000", gi[0][0][0], 32);
        check_model(1, 1, "orient");

        fill(-16, 16);
        run_pass(1, 0, 0, 0, "sign");
        for (int c = 0; c < ID; c++) begin
            chk("sign_11", gi[c][1][1], -288);
            chk("sign_00", gi[c][0][0], -128);
        end
        check_model(1, 1, "sign");

        // start mid-pass and in DONE must be ignored.
        fill_rand(0);
        run_pass(1, 50, 0, 1, "ign_start");
        check_model(1, 1, "ign_start");

        // Abort mid-pass, then a fresh pass.
        fill(16, 16);
        run_pass(1, 0, 100, 0, "abort");
        check_zero(1, "abort_gi");
        run_pass(1, 0, 0, 0, "fresh");
        check_model(1, 1, "fresh");

        for (int t = 0; t < 3; t++) begin
            fill_rand(t == 2);
            run_pass(1, 0, 0, 0, $sformatf("rand%0d", t));
            check_model(1, 1, $sformatf("rand%0d", t));
        end

        fill(16, 16);
        run_pass(2, 0, 0, 0, "dil2");
        for (int c = 0; c < ID; c++) begin
            chk("dil2_00", gi2[c][0][0], 128);
            chk("dil2_11", gi2[c][1][1], 128);
        end
        check_model(2, 2, "dil2");
        fill_rand(1);
        run_pass(2, 0, 0, 0, "dil2r");
        check_model(2, 2, "dil2r");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
